memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  MEM pipeline stage: consumes the EX-stage bundle (ALU result, rs2 value, read/write status, load sign, rd, WB type).
//  Drives a req/ready data-memory port, performs byte/half/word load extraction and store lane alignment.
//  Stalls upstream while a memory transaction is outstanding and forwards its result for hazard bypass.
//  Sits between execute and write_back; all logic on posedge clk.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles waiting on mem_ready before abort (range 2..255)
// PORTS
//  clk                       in   1   clock, all state updates on posedge
//  reset                     in   1   synchronous, active-high
//  pc                        in   32  instruction PC, passed through
//  result                    in   32  EX result; effective address for loads/stores
//  rs2_value_input           in   32  store data
//  read_status_input         in   2   `DM_NONE/`DM_BYTE/`DM_HALF/`DM_WORD (src/format.vh)
//  write_status_input        in   2   same encoding, store size
//  load_signed_input         in   1   1 = sign-extend loaded byte/half
//  destination_register_number_input in 5 rd
//  write_back_type_input     in   2   `WB_NORMAL/`WB_HICCUP/...; HICCUP = bubble
//  mem_req / mem_we          out  1   request valid / write
//  mem_addr                  out  32  word-aligned address {result[31:2],2'b00}
//  mem_wdata / mem_byte_en   out  32/4 lane-replicated store data / byte enables
//  mem_ready / mem_rdata     in   1/32 response strobe / read word
//  stall                     out  1   hold IF/ID/EX registers
//  pc_output, value_output   out  32  to write_back
//  destination_register_number_output out 5; write_back_type_output out 2
//  mem_error                 out  1   one-cycle pulse on timeout (or misalign, see CONFIGURATION)
//  value_forward/register_forward/forward_enable out 32/5/1  bypass from registered outputs
// BEHAVIOUR
//  - Reset: state IDLE, mem_req=0, mem_we=0, mem_byte_en=0, stall=0, mem_error=0, all data outputs 0,
//    write_back_type_output=`WB_HICCUP; timeout counter cleared. Reset mid-transaction drops it (no retry).
//  - mem op = type!=`WB_HICCUP && (read_status!=`DM_NONE || write_status!=`DM_NONE); read wins if both set.
//  - FSM IDLE: non-mem op -> registered to outputs, latency 1 cycle, stall=0.
//    Mem op -> stall=1 combinationally same cycle; capture bundle; next cycle mem_req=1, go WAIT.
//  - WAIT: mem_req/addr/wdata/byte_en held stable; counter++ each cycle. mem_ready=1 -> drop mem_req,
//    latch result, go DONE. Counter==TIMEOUT_CYCLES -> drop mem_req, pulse mem_error, output type `WB_HICCUP, go DONE.
//  - DONE: outputs valid for exactly one cycle, stall deasserts this cycle, return IDLE; an op
//    presented in DONE is accepted as in IDLE (back-to-back ops allowed).
//  - mem_ready outside WAIT ignored. Min mem-op latency: 3 cycles (accept, req+ready, done).
//  - Loads: lane=result[1:0]; BYTE picks rdata[8*lane+:8], HALF picks rdata[16*lane[1]+:16];
//    extend per load_signed_input; WORD unchanged.
//  - Stores: BYTE en=4'b0001<<lane, data {4{rs2[7:0]}}; HALF en=lane[1]?1100:0011, data {2{rs2[15:0]}};
//    WORD en=1111. Stores output type passes through; value_output=result.
//  - forward_enable = type_out==`WB_NORMAL && rd_out!=0 && !stall.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined: HALF with result[0]=1 or WORD with result[1:0]!=0 never issues mem_req;
//   stage outputs `WB_HICCUP, pulses mem_error, latency 1, no stall.
//  Undefined: low address bits ignored beyond lane selection; access issued as aligned.
// TESTING
//  - reset held 2 cycles mid-WAIT -> mem_req=0, stall=0, type_out=HICCUP next cycle.
//  - LB signed addr 0x103, rdata 0x80FF_FF11, ready after 2 cycles -> value_output 0xFFFF_FF80, stall 4 cycles.
//  - SH addr 0x102 rs2 0x1234_ABCD -> mem_we=1, byte_en 1100, wdata 0xABCD_ABCD, addr 0x100.
//  - ADD result 7 rd 5 -> value_output 7 next cycle, forward_enable=1, mem_req never set.
//  - mem_ready never high -> mem_error pulse after 16 WAIT cycles, type_out HICCUP, stall released.
//  - MEM_MISALIGN_CHECK_EN: LW addr 0x102 -> no mem_req, mem_error=1, type_out HICCUP.

Source files
------------

// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage between execute and write_back.
// Issues one data-memory transaction per load/store, extracts and extends
// loaded bytes/halves, aligns store data onto byte lanes, stalls upstream
// while a transaction is outstanding and aborts after TIMEOUT_CYCLES.
// Optional feature: define MEM_MISALIGN_CHECK_EN to reject misaligned
// half/word accesses with a one-cycle mem_error instead of issuing them.
//
// Memory port handshake: mem_req is the valid. Once raised, mem_req, mem_we,
// mem_addr, mem_wdata and mem_byte_en are held stable until the cycle in which
// mem_ready is sampled high (transfer completes on that clock edge) or the
// timeout fires. mem_ready is ignored whenever mem_req is low.
module memory_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] result,
  input  logic [31:0] rs2_value_input,
  input  logic [1:0]  read_status_input,
  input  logic [1:0]  write_status_input,
  input  logic        load_signed_input,
  input  logic [4:0]  destination_register_number_input,
  input  logic [1:0]  write_back_type_input,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] pc_output,
  output logic [31:0] value_output,
  output logic [4:0]  destination_register_number_output,
  output logic [1:0]  write_back_type_output,
  output logic        mem_error,
  output logic [31:0] value_forward,
  output logic [4:0]  register_forward,
  output logic        forward_enable,
  output logic [1:0]  o_dbg_state
);

  // Encodings shared with the rest of the core (format.vh)
  localparam logic [1:0] DM_NONE   = 2'd0;
  localparam logic [1:0] DM_BYTE   = 2'd1;
  localparam logic [1:0] DM_HALF   = 2'd2;
  localparam logic [1:0] DM_WORD   = 2'd3;
  localparam logic [1:0] WB_NORMAL = 2'd0;
  localparam logic [1:0] WB_HICCUP = 2'd1;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic        r_mem_req, r_mem_we, r_mem_error;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_byte_en;
  logic [31:0] r_pc, r_result;
  logic [4:0]  r_rd;
  logic [1:0]  r_type, r_size, r_lane;
  logic        r_is_load, r_signed;
  logic [31:0] r_pc_out, r_value_out;
  logic [4:0]  r_rd_out;
  logic [1:0]  r_type_out;

  logic        w_is_mem, w_is_load, w_misalign, w_can_accept, w_start, w_timeout;
  logic [1:0]  w_size, w_lane;
  logic [3:0]  w_st_en;
  logic [31:0] w_st_data, w_load_val;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  // Decode the incoming bundle; a read takes precedence when both sizes are set
  always_comb begin
    w_is_mem     = (write_back_type_input != WB_HICCUP) &&
                   ((read_status_input != DM_NONE) || (write_status_input != DM_NONE));
    w_is_load    = (read_status_input != DM_NONE);
    w_size       = w_is_load ? read_status_input : write_status_input;
    w_lane       = result[1:0];
`ifdef MEM_MISALIGN_CHECK_EN
    w_misalign   = w_is_mem && (((w_size == DM_HALF) && result[0]) ||
                                ((w_size == DM_WORD) && (result[1:0] != 2'b00)));
`else
    w_misalign   = 1'b0;
`endif
    w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE);
    w_start      = w_can_accept && w_is_mem && !w_misalign;
  end

  // Store lane alignment; loads read the whole word
  always_comb begin
    w_st_en   = 4'b1111;
    w_st_data = rs2_value_input;
    if (!w_is_load) begin
      case (w_size)
        DM_BYTE: begin
          w_st_en   = 4'b0001 << w_lane;
          w_st_data = {4{rs2_value_input[7:0]}};
        end
        DM_HALF: begin
          w_st_en   = w_lane[1] ? 4'b1100 : 4'b0011;
          w_st_data = {2{rs2_value_input[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load extraction from the returned word using the captured lane/size
  always_comb begin
    w_ld_byte = mem_rdata[{r_lane, 3'b000} +: 8];
    w_ld_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];
    case (r_size)
      DM_BYTE: w_load_val = {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};
      DM_HALF: w_load_val = {{16{r_signed & w_ld_half[15]}}, w_ld_half};
      default: w_load_val = mem_rdata;
    endcase
  end

  // Next-state logic; ready wins over timeout in the last wait cycle
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_start ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (mem_ready) begin
          w_next = S_DONE;
        end else if (r_cnt == LAST_CNT) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, memory port and stage output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_byte_en <= '0;
      r_mem_error   <= 1'b0;
      r_pc          <= '0;
      r_result      <= '0;
      r_rd          <= '0;
      r_type        <= WB_HICCUP;
      r_size        <= DM_NONE;
      r_lane        <= '0;
      r_is_load     <= 1'b0;
      r_signed      <= 1'b0;
      r_pc_out      <= '0;
      r_value_out   <= '0;
      r_rd_out      <= '0;
      r_type_out    <= WB_HICCUP;
    end else begin
      r_state     <= w_next;
      r_mem_error <= 1'b0;
      if (r_state == S_WAIT) begin
        if (mem_ready || w_timeout) begin
          r_mem_req   <= 1'b0;
          r_mem_we    <= 1'b0;
          r_pc_out    <= r_pc;
          r_rd_out    <= r_rd;
          r_value_out <= (mem_ready && r_is_load) ? w_load_val : r_result;
          r_type_out  <= mem_ready ? r_type : WB_HICCUP;
          r_mem_error <= !mem_ready;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else if (w_start) begin
        r_mem_req     <= 1'b1;
        r_mem_we      <= !w_is_load;
        r_mem_addr    <= {result[31:2], 2'b00};
        r_mem_wdata   <= w_st_data;
        r_mem_byte_en <= w_st_en;
        r_cnt         <= '0;
        r_pc          <= pc;
        r_result      <= result;
        r_rd          <= destination_register_number_input;
        r_type        <= write_back_type_input;
        r_size        <= w_size;
        r_lane        <= w_lane;
        r_is_load     <= w_is_load;
        r_signed      <= load_signed_input;
        r_type_out    <= WB_HICCUP;  // bubble to write_back while waiting
      end else begin
        r_pc_out    <= pc;
        r_value_out <= result;
        r_rd_out    <= destination_register_number_input;
        r_type_out  <= w_misalign ? WB_HICCUP : write_back_type_input;
        r_mem_error <= w_misalign;
      end
    end
  end

  assign mem_req        = r_mem_req;
  assign mem_we         = r_mem_we;
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_byte_en    = r_mem_byte_en;
  assign mem_error      = r_mem_error;
  assign pc_output      = r_pc_out;
  assign value_output   = r_value_out;
  assign destination_register_number_output = r_rd_out;
  assign write_back_type_output = r_type_out;
  assign stall          = !reset && ((r_state == S_WAIT) || w_start);
  assign value_forward  = r_value_out;
  assign register_forward = r_rd_out;
  assign forward_enable = (r_type_out == WB_NORMAL) && (r_rd_out != 5'd0) && !stall;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: reset, pass-through ALU ops, loads of
// every size/sign, store lane alignment, back-to-back accept, timeout abort,
// reset mid-transaction and the misalignment option.
module tb_memory_access;

  localparam logic [1:0] DM_NONE   = 2'd0;
  localparam logic [1:0] DM_BYTE   = 2'd1;
  localparam logic [1:0] DM_HALF   = 2'd2;
  localparam logic [1:0] DM_WORD   = 2'd3;
  localparam logic [1:0] WB_NORMAL = 2'd0;
  localparam logic [1:0] WB_HICCUP = 2'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, result, rs2;
  logic [1:0]  rd_st, wr_st, wb_type;
  logic        sgn;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we, mem_ready, stall, mem_error, forward_enable;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_output, value_output, value_forward;
  logic [3:0]  mem_byte_en;
  logic [4:0]  rd_out, register_forward;
  logic [1:0]  wb_type_out, dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  int          obs_stall;
  logic        obs_req;
  logic        obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_en;
  logic [1:0]  obs_type_wait;
  int          req_cycles;
  logic        seen;

  memory_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .pc(pc), .result(result), .rs2_value_input(rs2),
    .read_status_input(rd_st), .write_status_input(wr_st),
    .load_signed_input(sgn), .destination_register_number_input(rd_in),
    .write_back_type_input(wb_type), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
    .pc_output(pc_output), .value_output(value_output),
    .destination_register_number_output(rd_out),
    .write_back_type_output(wb_type_out), .mem_error(mem_error),
    .value_forward(value_forward), .register_forward(register_forward),
    .forward_enable(forward_enable), .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bubble();
    pc = '0; result = '0; rs2 = '0; rd_st = DM_NONE; wr_st = DM_NONE;
    sgn = 1'b0; rd_in = '0; wb_type = WB_HICCUP;
  endtask

  task automatic drive_op(input logic [1:0] rs, input logic [1:0] ws, input logic s,
                          input logic [31:0] p, input logic [31:0] r, input logic [31:0] v,
                          input logic [4:0] rd, input logic [1:0] t);
    rd_st = rs; wr_st = ws; sgn = s; pc = p; result = r; rs2 = v; rd_in = rd; wb_type = t;
  endtask

  // One memory op: accept, `delay` idle wait cycles, ready, then DONE with an
  // ALU op (result 0xD0E, rd 3) presented. Returns #2 into the DONE cycle.
  task automatic mem_op(input logic [1:0] rs, input logic [1:0] ws, input logic s,
                        input logic [31:0] addr, input logic [31:0] v,
                        input logic [31:0] rdata, input int delay);
    tick();
    drive_op(rs, ws, s, 32'h0000_0080, addr, v, 5'd7, WB_NORMAL);
    mem_ready = 1'b0;
    #1;
    obs_stall = int'(stall);
    tick();
    #1;
    obs_stall    += int'(stall);
    obs_req       = mem_req;
    obs_we        = mem_we;
    obs_addr      = mem_addr;
    obs_en        = mem_byte_en;
    obs_wdata     = mem_wdata;
    obs_type_wait = wb_type_out;
    for (int i = 0; i < delay; i++) begin
      tick();
      #1;
      obs_stall += int'(stall);
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    drive_op(DM_NONE, DM_NONE, 1'b0, 32'h0000_0084, 32'h0000_0D0E, '0, 5'd3, WB_NORMAL);
    #1;
    obs_stall += int'(stall);
  endtask

  // Directed stimulus and report
  initial begin
    reset = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
    drive_bubble();
    tick(); tick();
    #1;
    check_eq("rst_req",    32'(mem_req), 32'd0);
    check_eq("rst_stall",  32'(stall), 32'd0);
    check_eq("rst_type",   32'(wb_type_out), 32'(WB_HICCUP));
    check_eq("rst_err",    32'(mem_error), 32'd0);
    check_eq("rst_value",  value_output, 32'd0);
    check_eq("rst_byteen", 32'(mem_byte_en), 32'd0);
    reset = 1'b0;

    // ALU op: one-cycle latency, forwarding active, no memory request
    tick();
    drive_op(DM_NONE, DM_NONE, 1'b0, 32'h0000_0040, 32'd7, '0, 5'd5, WB_NORMAL);
    #1;
    check_eq("add_stall", 32'(stall), 32'd0);
    tick();
    drive_bubble();
    #1;
    check_eq("add_value", value_output, 32'd7);
    check_eq("add_rd",    32'(rd_out), 32'd5);
    check_eq("add_pc",    pc_output, 32'h0000_0040);
    check_eq("add_type",  32'(wb_type_out), 32'(WB_NORMAL));
    check_eq("add_fwd_en", 32'(forward_enable), 32'd1);
    check_eq("add_fwd_val", value_forward, 32'd7);
    check_eq("add_req",   32'(mem_req), 32'd0);
    tick();
    #1;
    check_eq("bubble_type", 32'(wb_type_out), 32'(WB_HICCUP));
    check_eq("bubble_fwd",  32'(forward_enable), 32'd0);

    // LB signed at 0x103, ready after two idle wait cycles
    exp_q.push_back(32'hFFFF_FF80);
    mem_op(DM_BYTE, DM_NONE, 1'b1, 32'h0000_0103, '0, 32'h80FF_FF11, 2);
    check_eq("lb_value",  value_output, exp_q.pop_front());
    check_eq("lb_stalls", 32'(obs_stall), 32'd4);
    check_eq("lb_addr",   obs_addr, 32'h0000_0100);
    check_eq("lb_req",    32'(obs_req), 32'd1);
    check_eq("lb_we",     32'(obs_we), 32'd0);
    check_eq("lb_wait_type", 32'(obs_type_wait), 32'(WB_HICCUP));
    check_eq("lb_type",   32'(wb_type_out), 32'(WB_NORMAL));
    check_eq("lb_pc",     pc_output, 32'h0000_0080);
    check_eq("lb_done_req", 32'(mem_req), 32'd0);
    check_eq("lb_fwd_en", 32'(forward_enable), 32'd1);

    // Unsigned byte, unsigned/signed half, word
    exp_q.push_back(32'h0000_00AB);
    mem_op(DM_BYTE, DM_NONE, 1'b0, 32'h0000_0101, '0, 32'h0000_AB00, 0);
    check_eq("lbu_value", value_output, exp_q.pop_front());
    check_eq("lbu_stalls", 32'(obs_stall), 32'd2);
    exp_q.push_back(32'h0000_8001);
    mem_op(DM_HALF, DM_NONE, 1'b0, 32'h0000_0202, '0, 32'h8001_7FFF, 0);
    check_eq("lhu_value", value_output, exp_q.pop_front());
    exp_q.push_back(32'hFFFF_9876);
    mem_op(DM_HALF, DM_NONE, 1'b1, 32'h0000_0200, '0, 32'h1234_9876, 1);
    check_eq("lh_value",  value_output, exp_q.pop_front());
    exp_q.push_back(32'hDEAD_BEEF);
    mem_op(DM_WORD, DM_NONE, 1'b1, 32'h0000_0300, '0, 32'hDEAD_BEEF, 0);
    check_eq("lw_value",  value_output, exp_q.pop_front());

    // Read and write both set: read wins
    exp_q.push_back(32'h1122_3344);
    mem_op(DM_WORD, DM_WORD, 1'b0, 32'h0000_0400, 32'h5555_5555, 32'h1122_3344, 0);
    check_eq("both_we",    32'(obs_we), 32'd0);
    check_eq("both_value", value_output, exp_q.pop_front());

    // SH at 0x102, then back-to-back ALU op accepted in DONE
    mem_op(DM_NONE, DM_HALF, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 32'hFFFF_FFFF, 0);
    check_eq("sh_we",     32'(obs_we), 32'd1);
    check_eq("sh_en",     32'(obs_en), 32'hC);
    check_eq("sh_wdata",  obs_wdata, 32'hABCD_ABCD);
    check_eq("sh_addr",   obs_addr, 32'h0000_0100);
    check_eq("sh_value",  value_output, 32'h0000_0102);
    check_eq("sh_type",   32'(wb_type_out), 32'(WB_NORMAL));
    check_eq("sh_done_stall", 32'(stall), 32'd0);
    tick();
    drive_bubble();
    #1;
    check_eq("b2b_value", value_output, 32'h0000_0D0E);
    check_eq("b2b_rd",    32'(rd_out), 32'd3);

    // SB and SW lane enables
    mem_op(DM_NONE, DM_BYTE, 1'b0, 32'h0000_0201, 32'h0000_0055, '0, 0);
    check_eq("sb_en",    32'(obs_en), 32'h2);
    check_eq("sb_wdata", obs_wdata, 32'h5555_5555);
    mem_op(DM_NONE, DM_WORD, 1'b0, 32'h0000_0300, 32'hA5A5_0001, '0, 0);
    check_eq("sw_en",    32'(obs_en), 32'hF);
    check_eq("sw_wdata", obs_wdata, 32'hA5A5_0001);

    // Timeout: mem_ready never rises
    tick();
    drive_op(DM_WORD, DM_NONE, 1'b0, 32'h0000_0090, 32'h0000_0500, '0, 5'd9, WB_NORMAL);
    tick();
    drive_bubble();
    #1;
    req_cycles = int'(mem_req);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      #1;
      if (mem_error) seen = 1'b1;
      else req_cycles += int'(mem_req);
    end
    check_eq("to_seen",   32'(seen), 32'd1);
    check_eq("to_req_cycles", 32'(req_cycles), 32'd16);
    check_eq("to_type",   32'(wb_type_out), 32'(WB_HICCUP));
    check_eq("to_stall",  32'(stall), 32'd0);
    check_eq("to_req",    32'(mem_req), 32'd0);
    tick();
    #1;
    check_eq("to_pulse",  32'(mem_error), 32'd0);

    // Reset held two cycles in the middle of a wait
    tick();
    drive_op(DM_WORD, DM_NONE, 1'b0, 32'h0000_00A0, 32'h0000_0600, '0, 5'd4, WB_NORMAL);
    tick();
    #1;
    check_eq("mid_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    #1;
    check_eq("mid_rst_req",   32'(mem_req), 32'd0);
    check_eq("mid_rst_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b0;
    drive_bubble();
    mem_ready = 1'b1;
    #1;
    check_eq("post_rst_type",  32'(wb_type_out), 32'(WB_HICCUP));
    check_eq("post_rst_stall", 32'(stall), 32'd0);
    check_eq("post_rst_state", 32'(dbg_state), 32'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    check_eq("no_retry_req", 32'(mem_req), 32'd0);
    check_eq("no_retry_type", 32'(wb_type_out), 32'(WB_HICCUP));

    // Misaligned word access at 0x102
`ifdef MEM_MISALIGN_CHECK_EN
    tick();
    drive_op(DM_WORD, DM_NONE, 1'b0, 32'h0000_00B0, 32'h0000_0102, '0, 5'd6, WB_NORMAL);
    #1;
    check_eq("mis_stall", 32'(stall), 32'd0);
    tick();
    drive_bubble();
    #1;
    check_eq("mis_req",   32'(mem_req), 32'd0);
    check_eq("mis_err",   32'(mem_error), 32'd1);
    check_eq("mis_type",  32'(wb_type_out), 32'(WB_HICCUP));
    tick();
    #1;
    check_eq("mis_pulse", 32'(mem_error), 32'd0);
`else
    exp_q.push_back(32'hCAFE_F00D);
    mem_op(DM_WORD, DM_NONE, 1'b0, 32'h0000_0102, '0, 32'hCAFE_F00D, 0);
    check_eq("mis_addr",  obs_addr, 32'h0000_0100);
    check_eq("mis_req",   32'(obs_req), 32'd1);
    check_eq("mis_value", value_output, exp_q.pop_front());
    check_eq("mis_err",   32'(mem_error), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
